// File: rtl/lcd_stream_reader.sv
// Pulls RGB565 pixels from a framed show-ahead FIFO and feeds an LCD timing driver,
// re-aligning to start-of-frame markers and substituting a blank colour on underrun.
//
// state      | meaning
// SEEK_SOP   | discard head words until a valid sop word is at the head
// WAIT_FRAME | sop word held at head, waiting for the driver's frame start
// STREAM     | one FIFO word per pixel request, framing checked on the fly
module lcd_stream_reader #(
    parameter int unsigned H_PIXELS    = 800,
    parameter int unsigned V_LINES     = 480,
    parameter logic [15:0] BLANK_COLOR = 16'h0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [18:0] fifo_rddata,
    input  logic        fifo_empty,
    output logic        fifo_rdreq,
    input  logic        lcd_frame_start,
    input  logic        pixel_req,
    output logic [15:0] pixel_data,
    output logic        pixel_valid,
    output logic [15:0] underrun_cnt,
    output logic        sync_err,
    output logic        frame_done
);

    localparam logic [18:0] LAST_PIX = 19'(H_PIXELS * V_LINES - 1);

    typedef enum logic [1:0] {
        SEEK_SOP   = 2'd0,
        WAIT_FRAME = 2'd1,
        STREAM     = 2'd2
    } state_t;

    state_t      state, state_nxt;
    logic [18:0] pix_cnt, pix_cnt_nxt;
    logic        head_sop, head_eop, head_valid;
    logic [15:0] head_data;
    logic        head_live, head_good;
    logic        pop, err_set, done_set, underrun_inc;
    logic [15:0] out_data;

    assign head_sop   = fifo_rddata[18];
    assign head_eop   = fifo_rddata[17];
    assign head_valid = fifo_rddata[16];
    assign head_data  = fifo_rddata[15:0];
    assign head_live  = !fifo_empty;
    assign head_good  = head_live && head_valid;

    always_comb begin
        state_nxt    = state;
        pix_cnt_nxt  = pix_cnt;
        pop          = 1'b0;
        err_set      = 1'b0;
        done_set     = 1'b0;
        underrun_inc = 1'b0;
        out_data     = BLANK_COLOR;
        case (state)
            SEEK_SOP: begin
                if (head_live) begin
                    if (head_sop && head_valid) state_nxt = WAIT_FRAME;
                    else                        pop       = 1'b1;
                end
            end
            WAIT_FRAME: begin
                if (lcd_frame_start) begin
                    pix_cnt_nxt = '0;
                    state_nxt   = STREAM;
                end
            end
            STREAM: begin
                // Framing violations leave the head in place so the next frame can use it.
                if (head_good && head_sop && (pix_cnt != '0)) begin
                    err_set   = 1'b1;
                    state_nxt = WAIT_FRAME;
                end else if (head_good && !head_sop && (pix_cnt == '0)) begin
                    err_set   = 1'b1;
                    state_nxt = SEEK_SOP;
                end else begin
                    if (head_live && !head_valid) pop = 1'b1;
                    if (pixel_req) begin
                        if (head_good) begin
                            pop      = 1'b1;
                            out_data = head_data;
                        end else begin
                            underrun_inc = 1'b1;
                        end
                        if (pix_cnt == LAST_PIX) begin
                            done_set  = 1'b1;
                            state_nxt = SEEK_SOP;
                            if (!(head_good && head_eop)) err_set = 1'b1;
                        end else begin
                            pix_cnt_nxt = pix_cnt + 19'd1;
                            if (head_good && head_eop) err_set = 1'b1;
                        end
                    end
                end
            end
            default: state_nxt = SEEK_SOP;
        endcase
    end

    assign fifo_rdreq = pop && rst_n;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= SEEK_SOP;
            pix_cnt <= '0;
        end else begin
            state   <= state_nxt;
            pix_cnt <= pix_cnt_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pixel_data   <= 16'h0000;
            pixel_valid  <= 1'b0;
            underrun_cnt <= 16'h0000;
            sync_err     <= 1'b0;
            frame_done   <= 1'b0;
        end else begin
            pixel_valid <= pixel_req;
            frame_done  <= done_set;
            if (pixel_req) pixel_data <= out_data;
            if (err_set) sync_err <= 1'b1;
            if (underrun_inc && (underrun_cnt != 16'hFFFF)) underrun_cnt <= underrun_cnt + 16'd1;
        end
    end

endmodule

// File: doc/lcd_stream_reader.md
LCD_STREAM_READER -- requirements
Module: lcd_stream_reader

Interface
REQ-001 SHALL have parameter H_PIXELS, default 800, active pixels per line.
REQ-002 SHALL have parameter V_LINES, default 480, active lines per frame.
REQ-003 SHALL have parameter BLANK_COLOR, default 16'h0000, RGB565 value output on underrun.
REQ-004 SHALL have port clk  input  1  single clock; all logic on its rising edge.
REQ-005 SHALL have port rst_n  input  1  reset; asynchronous, active-low.
REQ-006 SHALL have port fifo_rddata  input  19  show-ahead FIFO head word {sop, eop, valid, data[15:0]}, bit 18 = sop.
REQ-007 SHALL have port fifo_empty  input  1  FIFO empty flag; fifo_rddata is meaningful only when low.
REQ-008 SHALL have port fifo_rdreq  output  1  pop request; combinational, never asserted while fifo_empty is high.
REQ-009 SHALL have port lcd_frame_start  input  1  one-cycle pulse from the LCD timing driver at the start of a frame.
REQ-010 SHALL have port pixel_req  input  1  LCD driver requests one pixel this cycle.
REQ-011 SHALL have port pixel_data  output  16  RGB565 pixel, registered.
REQ-012 SHALL have port pixel_valid  output  1  high one cycle after each pixel_req.
REQ-013 SHALL have port underrun_cnt  output  16  count of pixels substituted with BLANK_COLOR; saturates at 16'hFFFF.
REQ-014 SHALL have port sync_err  output  1  sticky; set on any framing error, cleared only by reset.
REQ-015 SHALL have port frame_done  output  1  one-cycle pulse when the last pixel of a frame is output.

Function
REQ-016 SHALL implement states SEEK_SOP, WAIT_FRAME, STREAM.
REQ-017 In SEEK_SOP, SHALL pop every head word unless head has sop=1 and valid=1; on such a head, SHALL go to WAIT_FRAME without popping it.
REQ-018 In WAIT_FRAME, SHALL hold the head; on lcd_frame_start, SHALL clear the pixel counter (19 bit) and enter STREAM the next cycle.
REQ-019 lcd_frame_start in SEEK_SOP or STREAM SHALL be ignored.
REQ-020 In STREAM, a head word with valid=0 SHALL be popped regardless of pixel_req and never output.
REQ-021 In STREAM, pixel_req with a non-empty head having valid=1 SHALL pop it and output its data with 1-cycle latency.
REQ-022 In STREAM, pixel_req with FIFO empty or head valid=0 SHALL output BLANK_COLOR, increment underrun_cnt, and still advance the pixel counter.
REQ-023 pixel_req outside STREAM SHALL produce pixel_valid with BLANK_COLOR, without counting underrun.
REQ-024 A valid head with sop=1 reached in STREAM at pixel counter != 0 SHALL set sync_err and go to WAIT_FRAME without popping; unfinished pixels are not output.
REQ-025 At pixel counter 0 in STREAM, a valid head with sop=0 SHALL set sync_err and go to SEEK_SOP.
REQ-026 The pixel counter SHALL advance once per pixel_req in STREAM; at H_PIXELS*V_LINES-1 (383999 default) it SHALL pulse frame_done with that pixel, go to SEEK_SOP, and set sync_err if the popped word lacked eop=1 or was a blank substitution.
REQ-027 eop=1 popped before the final pixel SHALL set sync_err; streaming continues.
REQ-028 pixel_data SHALL hold its last value when pixel_valid is low.

Reset
REQ-029 On rst_n low, asynchronously: state SEEK_SOP, pixel counter 0, pixel_data 16'h0000, pixel_valid 0, underrun_cnt 0, sync_err 0, frame_done 0.
REQ-030 fifo_rdreq SHALL be 0 while rst_n is low.
REQ-031 Reset mid-frame SHALL abandon the frame; after release, the block resynchronises through SEEK_SOP.

Verification
REQ-032 Shall verify clean frame: FIFO preloaded with 384000 valid words (first sop, last eop, data = index[15:0]), frame_start, continuous pixel_req -> pixel_data 0,1,2,...; frame_done at pixel 383999; sync_err 0; underrun_cnt 0.
REQ-033 Shall verify seek: 5 junk words (sop=0) then a sop word -> 5 pops in SEEK_SOP, head held in WAIT_FRAME, first pixel = sop word data.
REQ-034 Shall verify underrun: FIFO empty for 10 pixel_req mid-frame -> 10 pixels BLANK_COLOR, underrun_cnt 10, frame_done still at request 384000.
REQ-035 Shall verify early sop: sop word at pixel 1000 -> sync_err 1, state WAIT_FRAME, sop word not popped until next frame start.
REQ-036 Shall verify invalid-word filtering: valid=0 words interleaved every 3rd entry -> never output; pixel sequence contiguous.
REQ-037 Shall verify reset mid-STREAM at pixel 5000 -> all outputs at reset values; next sop streams from pixel 0.
